mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single synchronous memory port of the core between the instruction-fetch unit and the load/store unit. It accepts one request at a time, holds the memory port for a fixed, parameterised latency, then returns read data and a one-cycle acknowledge to the winning requester. It sits between the pipeline's fetch and memory stages and the block RAM, inside `top`.

## Interface
- `ADDR_W`, 32, address width, byte address
- `DATA_W`, 32, data width; `DATA_W/8` byte enables
- `MEM_LAT`, 2, memory access cycles, legal range 1..15
- `clk`  in  1  the block's one clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  fetch request, level
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetch data, valid while `i_ack`=1
- `i_ack`  out  1  fetch done, one-cycle pulse
- `d_req`  in  1  load/store request, level
- `d_we`  in  1  1 = store
- `d_be`  in  DATA_W/8  byte enables for a store
- `d_addr`  in  ADDR_W  load/store address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`=1
- `d_ack`  out  1  load/store done, one-cycle pulse
- `mem_en`, `mem_we`  out  1  memory enable, write enable
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid in the last ACCESS cycle
- `busy`  out  1  high in ACCESS and DONE

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE:** if either request is high at the clock edge:
  - pick a winner;
  - latch the winner's address, write enable, byte enables and write data into the `mem_*` registers;
  - load the counter with `MEM_LAT-1`;
  - go to ACCESS.
- **ACCESS:**
  - `mem_en`=1 and all `mem_*` outputs hold steady.
  - Each cycle the counter decrements.
  - At counter==0 the block captures `mem_rdata` into the winner's rdata register and goes to DONE.
- **DONE:**
  - the winner's ack is 1 for exactly this cycle;
  - `mem_en`=0 and `mem_we`=0;
  - next state is IDLE unconditionally.
- **Fetch requests:** `mem_we`=0 and `mem_be` is all ones.
- **Store requests:** `d_rdata` is not updated and keeps its previous value.
- **Arbitration:** data has fixed priority over fetch (see Configuration).
- **Requester rules:**
  - A requester holds `req` and its operands stable from assertion until it sees ack.
  - It deasserts `req` in the cycle after ack unless it has a new access.
  - Requests are sampled only in IDLE. A `req` that is high in the IDLE cycle after DONE is a new transaction.
- **Reset, including mid-transaction:**
  - FSM returns to IDLE and the counter clears to 0;
  - all outputs go to 0: `mem_*`, `i_ack`, `d_ack`, `i_rdata`, `d_rdata`, `busy`;
  - the round-robin pointer resets to "fetch last".
  - The interrupted access is dropped with no ack.
- Operand changes while not granted are ignored.
- `req` dropped during ACCESS does not abort the access; the ack is still produced.

## Timing
- Request sampled at edge N → ACCESS occupies cycles N+1..N+`MEM_LAT` → ack in cycle N+`MEM_LAT`+1.
- Per-transaction cost is `MEM_LAT`+2 cycles (IDLE, ACCESS×`MEM_LAT`, DONE).
- Back-to-back throughput is one access per `MEM_LAT`+2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Counter width is 4 bits. `MEM_LAT`=1 gives one ACCESS cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, data wins every tie, so fetch can starve.
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - on a tie, the requester that did not win the previous grant wins;
  - the pointer updates on each grant;
  - the reset value "fetch last" means the first tie goes to data.
- A single requester always wins immediately in both modes.

## Structure
- Shared package `sbmips_pkg`:
  - state enum `arb_state_t` {IDLE, ACCESS, DONE};
  - grant encoding constants `GNT_I`, `GNT_D`;
  - `MEM_LAT` bounds.
- One sub-module, `mem_arb_pick`: a combinational winner select from `i_req`, `d_req` and the pointer. It contains the only `MEM_ARB_ROUND_ROBIN_EN`-dependent logic.

## Test plan
- Reset with `rst`=0, then release. Required: all outputs 0, FSM in IDLE.
- `MEM_LAT`=2, fetch `i_addr`=0x00400000, memory returns 0x8C020004. Required:
  - `mem_en` high for 2 cycles with `mem_addr`=0x00400000;
  - `i_ack` in the 3rd cycle after sampling with `i_rdata`=0x8C020004.
- Store `d_addr`=0x10010000, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011. Required: `mem_we`=1, `mem_be`=4'b0011 for 2 cycles; `d_ack` pulse; `d_rdata` unchanged.
- `i_req` and `d_req` both held high for 3 transactions. Required acks:
  - fixed priority: D, D, D;
  - with `MEM_ARB_ROUND_ROBIN_EN`: D, I, D.
- Assert `rst` in the 2nd ACCESS cycle. Required: `mem_en` drops asynchronously and no ack follows. After release, a held `req` is re-granted normally.
- `MEM_LAT`=1: the fetch ack arrives 2 cycles after sampling; a held `req` re-issues every 3 cycles.

Source files
------------

// File: rtl/sbmips_pkg.sv
// ============================================================================
// Module      : sbmips_pkg
// Description : Shared types and constants for the sbmips core memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sbmips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner select between fetch and load/store.
//               MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking,
//               otherwise data has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import sbmips_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_gnt,
    output logic gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that lost the previous grant wins.
    always_comb begin
        if (i_req && d_req) begin
            gnt = (last_gnt == GNT_I) ? GNT_D : GNT_I;
        end else begin
            gnt = d_req ? GNT_D : GNT_I;
        end
    end
`else
    logic [1:0] w_unused_pick;
    assign w_unused_pick = {i_req, last_gnt};

    always_comb begin
        gnt = d_req ? GNT_D : GNT_I;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous memory port between instruction fetch
//               and load/store; fixed MEM_LAT access, one-cycle ack.
//               Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import sbmips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int               BE_W       = DATA_W / 8;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_gnt;
    logic                w_pick;
    logic                w_take;
    logic                r_we;
    logic [BE_W-1:0]     r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    // r_gnt doubles as the round-robin pointer; reset value means fetch last.
    mem_arb_pick u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .last_gnt (r_gnt),
        .gnt      (w_pick)
    );

    assign w_take = (r_state == IDLE) && (i_req || d_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_req || d_req) w_next_state = ACCESS;
            ACCESS:  if (r_cnt == '0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_gnt     <= GNT_I;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_take) begin
            r_gnt <= w_pick;
            r_cnt <= c_CNT_LOAD;
            if (w_pick == GNT_D) begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_be    <= d_be;
                r_wdata <= d_wdata;
            end else begin
                r_addr  <= i_addr;
                r_we    <= 1'b0;
                r_be    <= '1;
                r_wdata <= '0;
            end
        end else if (r_state == ACCESS) begin
            if (r_cnt == '0) begin
                if (r_gnt == GNT_I) begin
                    r_i_rdata <= mem_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Outputs decode only registered state, so no input reaches an output.
    always_comb begin
        mem_en    = (r_state == ACCESS);
        mem_we    = (r_state == ACCESS) && r_we;
        mem_be    = r_be;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        busy      = (r_state != IDLE);
        i_ack     = (r_state == DONE) && (r_gnt == GNT_I);
        d_ack     = (r_state == DONE) && (r_gnt == GNT_D);
        i_rdata   = r_i_rdata;
        d_rdata   = r_d_rdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_acks = 0;
    exp_t        sb[$];
    int          sb1[$];
    logic [31:0] model_d;

    // Instance A: MEM_LAT = 2
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [3:0]  mem_be;

    // Instance B: MEM_LAT = 1, fetch only
    logic        i_req1 = 1'b0;
    logic [31:0] i_addr1 = '0;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_ack1, d_ack1, mem_en1, mem_we1, busy1;
    logic [3:0]  mem_be1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h0040_0000) ? 32'h8C02_0004 : (a ^ 32'hA5A5_0000);
    endfunction

    assign mem_rdata  = memfn(mem_addr);
    assign mem_rdata1 = memfn(mem_addr1);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0),
        .d_wdata(32'h0), .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst && (i_ack || d_ack)) begin
            n_acks++;
            if (sb.size() == 0) begin
                check("unexpected_ack", {i_ack, d_ack}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("ack_sel", {i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
                check("ack_cycle", cyc, e.cyc);
                check("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    int e1;
    always @(negedge clk) begin
        if (rst && i_ack1) begin
            if (sb1.size() == 0) begin
                check("lat1_unexpected_ack", i_ack1, 1'b0);
            end else begin
                e1 = sb1.pop_front();
                check("lat1_ack_cycle", cyc, e1);
                check("lat1_rdata", i_rdata1, 32'h8C02_0004);
            end
        end
    end

    // One complete transaction on instance A, with per-cycle port checks.
    task automatic do_access(input bit is_d, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        x.is_d = is_d;
        x.cyc  = cyc + 1 + 2;
        if (is_d && we) begin
            x.rdata = model_d;
        end else begin
            x.rdata = memfn(addr);
            if (is_d) model_d = x.rdata;
        end
        sb.push_back(x);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            check("acc_mem_en", mem_en, 1'b1);
            check("acc_mem_addr", mem_addr, addr);
            check("acc_mem_we", mem_we, is_d && we);
            check("acc_mem_be", mem_be, is_d ? be : 4'hF);
            if (is_d && we) check("acc_mem_wdata", mem_wdata, wdata);
        end
        @(negedge clk);
        check("done_mem_en", {mem_en, mem_we, busy}, 3'b001);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        model_d = '0;
        repeat (3) @(negedge clk);
        check("rst_mem", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, '0);
        check("rst_ack_busy", {i_ack, d_ack, busy}, 3'b000);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        do_access(1'b0, 1'b0, 4'h0, 32'h0040_0000, 32'h0);
        do_access(1'b1, 1'b0, 4'hF, 32'h1001_0010, 32'h0);
        do_access(1'b1, 1'b1, 4'b0011, 32'h1001_0000, 32'hDEAD_BEEF);
        check("store_keeps_d_rdata", d_rdata, memfn(32'h1001_0010));

        // Tie test starts from reset so the pointer is "fetch last".
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; model_d = '0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0040_0100;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0020;
        k = cyc;
        for (int n = 0; n < 3; n++) begin
            exp_t x;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            x.is_d = (n != 1);
`else
            x.is_d = 1'b1;
`endif
            x.rdata = x.is_d ? memfn(32'h1001_0020) : memfn(32'h0040_0100);
            x.cyc   = k + 3 + 4 * n;
            sb.push_back(x);
        end
        repeat (11) @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        check("tie_sb_drained", sb.size(), 0);

        // Reset during the second ACCESS cycle drops the access.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0040_0000;
        @(negedge clk);
        check("pre_rst_mem_en", mem_en, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_mem_en", {mem_en, busy, i_ack}, 3'b000);
        check("async_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_hold_out", {mem_en, busy, i_ack, d_ack, i_rdata}, '0);
        rst = 1'b1;
        model_d = '0;
        begin
            exp_t x;
            x.is_d = 1'b0; x.rdata = 32'h8C02_0004; x.cyc = cyc + 3;
            sb.push_back(x);
        end
        repeat (3) @(negedge clk);
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        check("regrant_sb_drained", sb.size(), 0);

        // MEM_LAT=1: held fetch acks every three cycles.
        @(negedge clk);
        i_req1 = 1'b1; i_addr1 = 32'h0040_0000;
        k = cyc;
        sb1.push_back(k + 2); sb1.push_back(k + 5); sb1.push_back(k + 8);
        @(negedge clk);
        check("lat1_en_c1", mem_en1, 1'b1);
        @(negedge clk);
        check("lat1_en_done", mem_en1, 1'b0);
        @(negedge clk);
        check("lat1_en_idle", {mem_en1, busy1}, 2'b00);
        @(negedge clk);
        check("lat1_en_reissue", mem_en1, 1'b1);
        repeat (4) @(negedge clk);
        i_req1 = 1'b0;
        repeat (4) @(negedge clk);
        check("lat1_sb_drained", sb1.size(), 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
